// File: rtl/updown_counter_disp.sv
// Up/down counter with programmable modulus, load, wrap/saturate limits,
// driving a multiplexed hex 7-segment display with a direction point.
module updown_counter_disp #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0,
    parameter int NDIG     = (WIDTH+3)/4,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir,
    output logic [6:0]       seg,
    output logic [NDIG-1:0]  an,
    output logic             dp
);

    localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    // Padded so every representable digit index selects a full nibble.
    localparam int PADW = (4*(2**DW) > WIDTH) ? 4*(2**DW) : WIDTH;

    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV-1);
    localparam logic [DW-1:0]    DIG_LAST   = DW'(NDIG-1);

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic [NDIG-1:0]  an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [PADW-1:0]  cnt_pad;
    logic [3:0]       nib;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        dir_d = dir_q;
        if (load) begin
            cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            dir_d = ud;
            if (ud) begin
                if (cnt_q == MAX_V) begin
                    tc_d  = 1'b1;
                    cnt_d = SATURATE ? MAX_V : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d  = 1'b1;
                    cnt_d = SATURATE ? '0 : MAX_V;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        dig_d   = dig_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dig_d   = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end
    end

    // Display outputs follow the current index/count with one cycle of latency.
    always_comb begin
        cnt_pad = PADW'(cnt_q);
        nib     = cnt_pad[int'(dig_q)*4 +: 4];
        an_d    = NDIG'(1) << dig_q;
        seg_d   = hex_font(nib);
        dp_d    = (dig_q == '0) && dir_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            dir_q   <= 1'b1;
            presc_q <= '0;
            dig_q   <= '0;
            an_q    <= NDIG'(1);
            seg_q   <= 7'h3F;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign count = cnt_q;
    assign tc    = tc_q;
    assign dir   = dir_q;
    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_updown_counter_disp.sv
// Bench for updown_counter_disp: three configurations driven in lockstep and
// compared each cycle against an arithmetic reference model.
module tb_updown_counter_disp;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, ud, load;
    logic [7:0] load_val;

    logic [3:0] cnt0, cnt1;
    logic [7:0] cnt2;
    logic       tc0, tc1, tc2, dir0, dir1, dir2, dp0, dp1, dp2;
    logic [6:0] seg0, seg1, seg2;
    logic [0:0] an0, an1;
    logic [1:0] an2;

    int checks = 0;
    int failures = 0;

    // Per-instance configuration: width, modulus limit, saturate, scan divider, digits.
    int P_W[3]   = '{4, 4, 8};
    int P_MAX[3] = '{9, 9, 255};
    int P_SAT[3] = '{0, 1, 0};
    int P_SD[3]  = '{4, 1, 2};
    int P_ND[3]  = '{1, 1, 2};
    int FONT[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                     'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    int m_cnt[3], m_tc[3], m_dir[3], m_presc[3], m_dig[3], m_an[3], m_seg[3], m_dp[3];

    updown_counter_disp #(.WIDTH(4), .MAX(9), .SATURATE(1'b0), .SCAN_DIV(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val[3:0]),
        .count(cnt0), .tc(tc0), .dir(dir0), .seg(seg0), .an(an0), .dp(dp0));

    updown_counter_disp #(.WIDTH(4), .MAX(9), .SATURATE(1'b1), .SCAN_DIV(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val[3:0]),
        .count(cnt1), .tc(tc1), .dir(dir1), .seg(seg1), .an(an1), .dp(dp1));

    updown_counter_disp #(.WIDTH(8), .SATURATE(1'b0), .SCAN_DIV(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val),
        .count(cnt2), .tc(tc2), .dir(dir2), .seg(seg2), .an(an2), .dp(dp2));

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_dir[i] = 1; m_presc[i] = 0;
            m_dig[i] = 0; m_an[i] = 1; m_seg[i] = 'h3F; m_dp[i] = 1;
        end
    endtask

    task automatic model_step(input int i, input bit e, input bit u, input bit l, input int lv);
        int mx = P_MAX[i];
        int v;
        bit at_lim;
        m_an[i]  = 1 << m_dig[i];
        m_seg[i] = FONT[(m_cnt[i] >> (4*m_dig[i])) & 15];
        m_dp[i]  = (m_dig[i] == 0 && m_dir[i] == 1) ? 1 : 0;
        if (m_presc[i] == P_SD[i]-1) begin
            m_presc[i] = 0;
            m_dig[i]   = (m_dig[i] + 1) % P_ND[i];
        end else begin
            m_presc[i]++;
        end
        if (l) begin
            v = lv & ((1 << P_W[i]) - 1);
            m_cnt[i] = (v > mx) ? mx : v;
            m_tc[i]  = 0;
        end else if (e) begin
            m_dir[i] = u;
            at_lim   = u ? (m_cnt[i] == mx) : (m_cnt[i] == 0);
            m_tc[i]  = at_lim;
            if (!(at_lim && P_SAT[i] == 1))
                m_cnt[i] = u ? (m_cnt[i] + 1) % (mx + 1) : (m_cnt[i] + mx) % (mx + 1);
        end else begin
            m_tc[i] = 0;
        end
    endtask

    task automatic chk_inst(input int i, input string ph, input int c, input int t, input int d,
                            input int a, input int s, input int p);
        chk_val($sformatf("%s u%0d count", ph, i), c, m_cnt[i]);
        chk_val($sformatf("%s u%0d tc", ph, i), t, m_tc[i]);
        chk_val($sformatf("%s u%0d dir", ph, i), d, m_dir[i]);
        chk_val($sformatf("%s u%0d an", ph, i), a, m_an[i]);
        chk_val($sformatf("%s u%0d seg", ph, i), s, m_seg[i]);
        chk_val($sformatf("%s u%0d dp", ph, i), p, m_dp[i]);
    endtask

    task automatic check_all(input string ph);
        chk_inst(0, ph, int'(cnt0), int'(tc0), int'(dir0), int'(an0), int'(seg0), int'(dp0));
        chk_inst(1, ph, int'(cnt1), int'(tc1), int'(dir1), int'(an1), int'(seg1), int'(dp1));
        chk_inst(2, ph, int'(cnt2), int'(tc2), int'(dir2), int'(an2), int'(seg2), int'(dp2));
    endtask

    // Called at a falling edge: drive, clock once, sample on the next falling edge.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [7:0] lv, input string ph);
        en = e; ud = u; load = l; load_val = lv;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, e, u, l, int'(lv));
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++)
            cycle(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, 8'($urandom), "rand");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ud = 1'b0; load = 1'b0; load_val = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        model_reset();
        check_all("reset");
        rst = 1'b1;

        repeat (12) cycle(1'b1, 1'b1, 1'b0, 8'h00, "up12");
        chk_val("up12 final u0 count", int'(cnt0), 2);

        cycle(1'b0, 1'b0, 1'b1, 8'h00, "load0");
        cycle(1'b1, 1'b0, 1'b0, 8'h00, "downwrap");
        chk_val("downwrap u0 count", int'(cnt0), 9);
        chk_val("downwrap u0 tc", int'(tc0), 1);
        chk_val("downwrap u0 dir", int'(dir0), 0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle");
        chk_val("idle u0 tc", int'(tc0), 0);

        cycle(1'b0, 1'b1, 1'b1, 8'h09, "load9");
        repeat (3) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h00, "sat_hi");
            chk_val("sat_hi u1 count", int'(cnt1), 9);
            chk_val("sat_hi u1 tc", int'(tc1), 1);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00, "load0b");
        repeat (3) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00, "sat_lo");
            chk_val("sat_lo u1 count", int'(cnt1), 0);
            chk_val("sat_lo u1 tc", int'(tc1), 1);
        end

        cycle(1'b1, 1'b1, 1'b1, 8'h0F, "clamp");
        chk_val("clamp u0 count", int'(cnt0), 9);
        chk_val("clamp u0 tc", int'(tc0), 0);
        chk_val("clamp u0 dir", int'(dir0), 0);

        cycle(1'b1, 1'b1, 1'b0, 8'h00, "setdir");
        cycle(1'b0, 1'b1, 1'b1, 8'hA5, "loadA5");
        repeat (8) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, "disp");
            if (an2 == 2'b01) begin
                chk_val("disp u2 seg lo", int'(seg2), 'h6D);
                chk_val("disp u2 dp lo", int'(dp2), 1);
            end else begin
                chk_val("disp u2 seg hi", int'(seg2), 'h77);
                chk_val("disp u2 dp hi", int'(dp2), 0);
            end
        end

        rand_cycles(400);

        cycle(1'b0, 1'b1, 1'b1, 8'h05, "load5");
        cycle(1'b0, 1'b1, 1'b0, 8'h00, "pre_arst");
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("arst");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b1;

        rand_cycles(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
